// File: rtl/lcd1602_frame_scheduler_if.sv
// Host-side port of the LCD1602 frame scheduler: character writes, redraw
// request and scheduler status.
interface lcd1602_frame_scheduler_if;
   logic       wr_en;
   logic [4:0] wr_addr;
   logic [7:0] wr_data;
   logic       refresh_req;
   logic       init_done;
   logic       busy;
   logic       frame_done;

   modport master (
      output wr_en, wr_addr, wr_data, refresh_req,
      input  init_done, busy, frame_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, refresh_req,
      output init_done, busy, frame_done
   );
endinterface

// File: rtl/lcd1602_frame_scheduler.sv
// LCD1602 bus owner: power-up wait, init command sequence, then 2x16 panel
// refresh from a 32-byte frame buffer, with per-byte EN pulses and waits.
module lcd1602_frame_scheduler #(
   parameter int SETUP_CYC    = 2,
   parameter int EN_CYC       = 10,
   parameter int CMD_WAIT_CYC = 1000,
   parameter int CLR_WAIT_CYC = 40000,
   parameter int PWRUP_CYC    = 400000
) (
   input  logic                     lcd_clk_in,
   input  logic                     lcd_rst_in,
   lcd1602_frame_scheduler_if.slave host,
   output logic [7:0]               LCD_DATA,
   output logic                     LCD_RS,
   output logic                     LCD_RW,
   output logic                     LCD_EN
);

   localparam int MAX_A   = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
   localparam int MAX_B   = (CMD_WAIT_CYC > EN_CYC) ? CMD_WAIT_CYC : EN_CYC;
   localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_CYC = (MAX_C > SETUP_CYC) ? MAX_C : SETUP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);

   typedef enum logic [2:0] {
      S_PWRUP, S_INIT, S_IDLE, S_ADDR1, S_CHARS1, S_ADDR2, S_CHARS2
   } state_t;

   typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_WAIT} phase_t;

   state_t           state_q, state_d;
   phase_t           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             en_q, en_d;
   logic             init_done_q, init_done_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             dirty_q, dirty_d;
   logic             byte_done;
   logic             start_byte;
   logic [CNT_W-1:0] wait_last;
   logic [7:0]       buffer [32];

   function automatic logic [7:0] init_cmd(input logic [3:0] i);
      case (i)
         4'd0, 4'd1: init_cmd = 8'h38;
         4'd2:       init_cmd = 8'h0C;
         4'd3:       init_cmd = 8'h06;
         default:    init_cmd = 8'h01;
      endcase
   endfunction

   // Clear Display needs the long settle time; everything else uses the short one.
   assign wait_last = (!rs_q && data_q == 8'h01) ? CLR_LAST : CMD_LAST;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      cnt_d        = cnt_q + CNT_W'(1);
      idx_d        = idx_q;
      data_d       = data_q;
      rs_d         = rs_q;
      en_d         = en_q;
      init_done_d  = init_done_q;
      frame_done_d = 1'b0;
      dirty_d      = dirty_q;
      byte_done    = 1'b0;
      start_byte   = 1'b0;

      if (state_q != S_PWRUP && state_q != S_IDLE) begin
         case (phase_q)
            PH_SETUP: if (cnt_q == SETUP_LAST) begin
               phase_d = PH_EN;
               cnt_d   = '0;
               en_d    = 1'b1;
            end
            PH_EN: if (cnt_q == EN_LAST) begin
               phase_d = PH_WAIT;
               cnt_d   = '0;
               en_d    = 1'b0;
            end
            default: if (cnt_q == wait_last) byte_done = 1'b1;
         endcase
      end

      case (state_q)
         S_PWRUP: if (cnt_q == PWRUP_LAST) begin
            state_d    = S_INIT;
            idx_d      = '0;
            start_byte = 1'b1;
         end
         S_INIT: if (byte_done) begin
            if (idx_q == 4'd4) begin
               state_d     = S_IDLE;
               init_done_d = 1'b1;
            end else begin
               idx_d      = idx_q + 4'd1;
               start_byte = 1'b1;
            end
         end
         S_IDLE: begin
            cnt_d = '0;
            if (dirty_q || host.refresh_req) begin
               state_d    = S_ADDR1;
               dirty_d    = 1'b0;
               start_byte = 1'b1;
            end
         end
         S_ADDR1: if (byte_done) begin
            state_d    = S_CHARS1;
            idx_d      = '0;
            start_byte = 1'b1;
         end
         S_CHARS1: if (byte_done) begin
            if (idx_q == 4'd15) state_d = S_ADDR2;
            else                idx_d   = idx_q + 4'd1;
            start_byte = 1'b1;
         end
         S_ADDR2: if (byte_done) begin
            state_d    = S_CHARS2;
            idx_d      = '0;
            start_byte = 1'b1;
         end
         S_CHARS2: if (byte_done) begin
            if (idx_q == 4'd15) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end else begin
               idx_d      = idx_q + 4'd1;
               start_byte = 1'b1;
            end
         end
         default: state_d = S_PWRUP;
      endcase

      // Characters are sampled from the buffer only here, at the start of their byte.
      if (start_byte) begin
         phase_d = PH_SETUP;
         cnt_d   = '0;
         case (state_d)
            S_INIT:   begin rs_d = 1'b0; data_d = init_cmd(idx_d);        end
            S_ADDR1:  begin rs_d = 1'b0; data_d = 8'h80;                  end
            S_ADDR2:  begin rs_d = 1'b0; data_d = 8'hC0;                  end
            S_CHARS1: begin rs_d = 1'b1; data_d = buffer[{1'b0, idx_d}];  end
            S_CHARS2: begin rs_d = 1'b1; data_d = buffer[{1'b1, idx_d}];  end
            default:  ;
         endcase
      end

      if (host.wr_en) dirty_d = 1'b1;
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge lcd_clk_in or posedge lcd_rst_in) begin
      if (lcd_rst_in) begin
         state_q      <= S_PWRUP;
         phase_q      <= PH_SETUP;
         cnt_q        <= '0;
         idx_q        <= '0;
         data_q       <= 8'h00;
         rs_q         <= 1'b0;
         en_q         <= 1'b0;
         init_done_q  <= 1'b0;
         busy_q       <= 1'b1;
         frame_done_q <= 1'b0;
         dirty_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         data_q       <= data_d;
         rs_q         <= rs_d;
         en_q         <= en_d;
         init_done_q  <= init_done_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         dirty_q      <= dirty_d;
      end
   end

   // Frame buffer resets to spaces so the first frame blanks the panel.
   always_ff @(posedge lcd_clk_in or posedge lcd_rst_in) begin
      if (lcd_rst_in) begin
         for (int i = 0; i < 32; i++) buffer[i] <= 8'h20;
      end else if (host.wr_en) begin
         buffer[host.wr_addr] <= host.wr_data;
      end
   end

   assign LCD_DATA        = data_q;
   assign LCD_RS          = rs_q;
   assign LCD_RW          = 1'b0;
   assign LCD_EN          = en_q;
   assign host.init_done  = init_done_q;
   assign host.busy       = busy_q;
   assign host.frame_done = frame_done_q;

endmodule

// File: doc/lcd1602_frame_scheduler.md
Name: lcd1602_frame_scheduler

Overview:
Owns the LCD1602 pin bus and sequences every transfer on it. Runs the power-up and initialisation command sequence with datasheet-safe timing. Then refreshes the 2x16 panel from an internal 32-byte frame buffer, which host logic writes through a simple write port. Replaces free-running state stepping with per-byte EN pulse generation and per-command wait times, all counted in system clock cycles.

Parameters:
SETUP_CYC, 2, cycles with RS/DATA stable before EN rises
EN_CYC, 10, EN high width in cycles (500 ns at 20 MHz)
CMD_WAIT_CYC, 1000, wait after EN falls for normal command/data (50 us)
CLR_WAIT_CYC, 40000, wait after EN falls for Clear Display 0x01 (2 ms)
PWRUP_CYC, 400000, idle time after reset before first command (20 ms)

Ports:
lcd_clk_in  in  1  system clock (20 MHz nominal)
lcd_rst_in  in  1  asynchronous reset, active-high
wr_en  in  1  host write strobe, one character per cycle
wr_addr  in  5  character index: 0-15 line 1, 16-31 line 2
wr_data  in  8  character code
refresh_req  in  1  force a full redraw even if nothing changed
init_done  out  1  high once the init sequence has completed
busy  out  1  high while any LCD bus transfer or wait is in progress
frame_done  out  1  one-cycle pulse after the last byte of a frame has finished its wait
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  tied 0 (write only)
LCD_EN  out  1  LCD enable strobe

Behaviour:
- Reset values (asynchronous): LCD_DATA=0x00, LCD_RS=0, LCD_EN=0, init_done=0, busy=1, frame_done=0, dirty=1, all 32 buffer bytes=0x20 (space), FSM=PWRUP. LCD_RW is constant 0.
- Byte transfer engine:
  - Phase SETUP: drive RS/DATA, hold for SETUP_CYC cycles.
  - Phase EN: LCD_EN=1 for EN_CYC cycles.
  - Phase WAIT: LCD_EN=0, RS/DATA held unchanged, for CLR_WAIT_CYC cycles if the byte is command 0x01, otherwise CMD_WAIT_CYC.
  - Normal byte total = SETUP_CYC+EN_CYC+CMD_WAIT_CYC cycles. The next byte starts its SETUP phase on the following cycle.
- FSM states:
  - PWRUP: count PWRUP_CYC cycles, then go to INIT.
  - INIT: send commands 0x38, 0x38, 0x0C, 0x06, 0x01 in that order. After the last wait, set init_done=1 and go to IDLE.
  - IDLE: busy=0. If dirty or refresh_req is high, clear dirty and go to ADDR1. Otherwise stay.
  - ADDR1: command 0x80 -> CHARS1.
  - CHARS1: data bytes at buffer[0..15] -> ADDR2.
  - ADDR2: command 0xC0 -> CHARS2.
  - CHARS2: data bytes at buffer[16..31]. After the last wait, pulse frame_done for 1 cycle and return to IDLE.
- busy=1 in every state except IDLE.
- Frame length = 34 bytes, all of normal timing.
- Each character byte is read from the buffer on the first SETUP cycle of that byte. It is not re-read mid-transfer.
- Buffer writes are accepted in every state, including PWRUP and INIT; wr_addr selects the byte.
  - Every write sets dirty.
  - If a write lands on the same cycle that IDLE clears dirty, dirty ends set (write wins), so another frame follows.
  - A write during a frame sets dirty, so exactly one further frame follows, even if the written index had not yet been sent.
- refresh_req is level-sampled only in IDLE. Held high, it produces back-to-back frames.
- After reset the first frame (all spaces) follows init automatically, because dirty resets to 1.
- Reset asserted mid-transfer: LCD_EN drops to 0 immediately and the full PWRUP+INIT sequence restarts.

Test Plan:
Use SETUP_CYC=2, EN_CYC=3, CMD_WAIT_CYC=5, CLR_WAIT_CYC=20, PWRUP_CYC=50.
1. Release reset, no stimulus -> first LCD_EN rise at cycle 52 with DATA=0x38, RS=0. Init bytes 0x38,0x38,0x0C,0x06,0x01 follow, with 10-cycle spacing and 25 cycles for 0x01. init_done rises, then a 34-byte frame (0x80, 16x0x20, 0xC0, 16x0x20) runs. frame_done pulses once; busy=0 afterwards.
2. In IDLE, write 0x41 to addr 0 and 0x42 to addr 31 -> one frame. Byte 2 is RS=1 DATA=0x41, byte 34 is RS=1 DATA=0x42. Each EN high exactly 3 cycles; 340 cycles from frame start to frame_done.
3. Write addr 5 = 0x55 during CHARS2 of a running frame -> that frame completes unchanged, then exactly one more frame shows 0x55 at byte 7, then IDLE.
4. Write on the same cycle IDLE starts a frame -> two frames run, then IDLE.
5. Hold refresh_req=1 with no writes -> frame_done pulses every 340+1 cycles continuously. Drop it -> return to IDLE after the current frame.
6. Assert lcd_rst_in while LCD_EN=1 mid-frame -> LCD_EN=0, init_done=0, busy=1 the same cycle. Buffer returns to spaces and scenario 1 timing repeats.
